// File: rtl/trap_ctrl_pkg.sv
// Shared constants and trap-kind encoding for the trap sequencer.
// The IRQ kind and cause only exist when TRAP_CTRL_IRQ_EN is defined.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
`ifdef TRAP_CTRL_IRQ_EN
  localparam logic [31:0] CAUSE_IRQ_EXT_M = 32'h8000_000B;
`endif

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    KIND_ECALL = 2'd0,
    KIND_MRET  = 2'd1
`ifdef TRAP_CTRL_IRQ_EN
    , KIND_IRQ = 2'd2
`endif
  } trap_kind_e;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: stalls, writes mstatus/mepc/mcause one per cycle, then flushes and redirects.
// Define TRAP_CTRL_IRQ_EN to build the external interrupt path; otherwise irq_i is ignored.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DATA_WIDTH-1:0]     exception_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic                      hold_i,
  input  logic                      irq_i,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
  input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      stall_o,
  output logic                      flush_o,
  output logic                      redirect_o,
  output logic [ADDR_WIDTH-1:0]     redirect_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MSTATUS = 3'd1,
    S_W_MEPC    = 3'd2,
    S_W_MCAUSE  = 3'd3,
    S_JUMP      = 3'd4
  } state_e;

  state_e                r_state;
  state_e                w_nextState;
  trap_kind_e            r_kind;
  trap_kind_e            w_detKind;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic [DATA_WIDTH-1:0] r_cause;
  logic [DATA_WIDTH-1:0] w_detCause;
  logic [DATA_WIDTH-1:0] w_mstatusNew;
  logic                  w_take;
  logic                  w_unused;

`ifdef TRAP_CTRL_IRQ_EN
  assign w_unused = ^{exception_i[DATA_WIDTH-1:2], csr_mepc_i[1:0], csr_mtvec_i[1:0]};
`else
  assign w_unused = ^{exception_i[DATA_WIDTH-1:2], csr_mepc_i[1:0], csr_mtvec_i[1:0], irq_i};
`endif

  // Detection is gated by reset so every output reads 0 while rst_n_i is low.
  always_comb begin
    w_take     = 1'b0;
    w_detKind  = KIND_ECALL;
    w_detCause = DATA_WIDTH'(CAUSE_ECALL_M);
    if (exception_i[1]) begin
      w_take = 1'b1;
    end else if (exception_i[0]) begin
      w_take     = 1'b1;
      w_detKind  = KIND_MRET;
      w_detCause = '0;
    end
`ifdef TRAP_CTRL_IRQ_EN
    else if (irq_i && csr_mstatus_i[MSTATUS_MIE]) begin
      w_take     = 1'b1;
      w_detKind  = KIND_IRQ;
      w_detCause = DATA_WIDTH'(CAUSE_IRQ_EXT_M);
    end
`endif
    if (!rst_n_i || (r_state != S_IDLE) || hold_i) begin
      w_take = 1'b0;
    end
  end

  always_comb begin
    w_mstatusNew = csr_mstatus_i;
    if (r_kind == KIND_MRET) begin
      w_mstatusNew[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
      w_mstatusNew[MSTATUS_MPIE] = 1'b1;
    end else begin
      w_mstatusNew[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
      w_mstatusNew[MSTATUS_MIE]  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_kind  <= KIND_ECALL;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_take) begin
        r_kind  <= w_detKind;
        r_epc   <= inst_addr_i;
        r_cause <= w_detCause;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    stall_o       = 1'b0;
    csr_we_o      = 1'b0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_take;
        if (w_take) w_nextState = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata_o = w_mstatusNew;
        w_nextState = (r_kind == KIND_MRET) ? S_JUMP : S_W_MEPC;
      end
      S_W_MEPC: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
        csr_wdata_o = DATA_WIDTH'(r_epc);
        w_nextState = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        csr_wdata_o = r_cause;
        w_nextState = S_JUMP;
      end
      S_JUMP: begin
        stall_o     = 1'b1;
        flush_o     = 1'b1;
        redirect_o  = 1'b1;
        // All CSR writes have landed by now, so mepc/mtvec are current.
        if (r_kind == KIND_MRET) redirect_pc_o = {csr_mepc_i[ADDR_WIDTH-1:2], 2'b00};
        else                     redirect_pc_o = {csr_mtvec_i[ADDR_WIDTH-1:2], 2'b00};
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus random traffic against a per-trap sequence model.
// Expectations follow TRAP_CTRL_IRQ_EN the same way the design does.
module tb_trap_ctrl;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        flush;
    logic        redirect;
    logic [31:0] pc;
  } outRec_t;

`ifdef TRAP_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] exception_i;
  logic [31:0] inst_addr_i;
  logic        hold_i;
  logic        irq_i;
  logic [31:0] csr_mstatus_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mtvec_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  logic [31:0] mMstatus, mMepc, mMtvec, mMcause;
  outRec_t     expQ[$];
  logic        pendValid;
  outRec_t     pendRec;
  int          testsRun = 0;
  int          testsFailed = 0;

  assign csr_mstatus_i = mMstatus;
  assign csr_mepc_i    = mMepc;
  assign csr_mtvec_i   = mMtvec;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .exception_i(exception_i), .inst_addr_i(inst_addr_i),
    .hold_i(hold_i), .irq_i(irq_i), .csr_mstatus_i(csr_mstatus_i), .csr_mepc_i(csr_mepc_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  // Model: on an accepted trap, queue the whole cycle-by-cycle output sequence it must produce.
  task automatic buildTrap(input logic [31:0] exc, input logic [31:0] pc, input logic hold, input logic irq);
    outRec_t r;
    int kind;
    kind = 0;
    if (hold) return;
    if (exc[1]) kind = 1;
    else if (exc[0]) kind = 2;
    else if (IRQ_EN && irq && mMstatus[3]) kind = 3;
    if (kind == 0) return;
    r = '0; r.stall = 1'b1;
    expQ.push_back(r);
    r.we = 1'b1; r.waddr = 12'h300;
    if (kind == 2) r.wdata = (mMstatus & ~32'h88) | (32'(mMstatus[7]) << 3) | 32'h80;
    else           r.wdata = (mMstatus & ~32'h88) | (32'(mMstatus[3]) << 7);
    expQ.push_back(r);
    if (kind != 2) begin
      r.waddr = 12'h341; r.wdata = pc;
      expQ.push_back(r);
      r.waddr = 12'h342; r.wdata = (kind == 1) ? 32'd11 : 32'h8000_000B;
      expQ.push_back(r);
    end
    r = '0; r.stall = 1'b1; r.flush = 1'b1; r.redirect = 1'b1;
    r.pc = (kind == 2) ? (mMepc & ~32'h3) : (mMtvec & ~32'h3);
    expQ.push_back(r);
  endtask

  task automatic applyPending();
    if (pendValid) begin
      case (pendRec.waddr)
        12'h300: mMstatus = pendRec.wdata;
        12'h341: mMepc    = pendRec.wdata;
        12'h342: mMcause  = pendRec.wdata;
        default: ;
      endcase
    end
    pendValid = 1'b0;
  endtask

  // Called at posedge+1; drives one cycle, returns observed and modelled outputs sampled at the negedge.
  task automatic stepCycle(input logic [31:0] exc, input logic [31:0] pc, input logic hold,
                           input logic irq, output outRec_t obs, output outRec_t exp);
    applyPending();
    exception_i = exc; inst_addr_i = pc; hold_i = hold; irq_i = irq;
    if (expQ.size() == 0) buildTrap(exc, pc, hold, irq);
    exp = (expQ.size() != 0) ? expQ.pop_front() : outRec_t'('0);
    @(negedge clk_i);
    obs = {stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, redirect_o, redirect_pc_o};
    if (exp.we) begin pendValid = 1'b1; pendRec = exp; end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    outRec_t obs;
    rst_n_i = 1'b0; exception_i = 32'h2; irq_i = 1'b1; hold_i = 1'b0; inst_addr_i = 32'h10;
    mMstatus = 32'h8; mMepc = 32'h0; mMtvec = 32'h200; mMcause = 32'h0;
    expQ.delete(); pendValid = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      obs = {stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, redirect_o, redirect_pc_o};
      testsRun++;
      if (obs !== outRec_t'('0)) begin
        testsFailed++;
        $display("[TB] FAIL reset%0d: got %h expected 0", i, obs);
      end
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    exception_i = '0; irq_i = 1'b0;
  endtask

  task automatic test_ecall();
    outRec_t obs, exp;
    mMstatus = 32'h8; mMtvec = 32'h200;
    for (int i = 0; i < 6; i++) begin
      stepCycle((i == 0) ? 32'h2 : 32'h0, 32'h100, 1'b0, 1'b0, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ecall c%0d: got %h expected %h", i, obs, exp);
      end
      if (i == 4) begin
        testsRun++;
        if (obs.pc !== 32'h200 || obs.redirect !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL ecall_target: got %h expected 00000200", obs.pc);
        end
      end
    end
  endtask

  task automatic test_mret();
    outRec_t obs, exp;
    mMstatus = 32'h80; mMepc = 32'h104;
    for (int i = 0; i < 4; i++) begin
      stepCycle((i == 0) ? 32'h1 : 32'h0, 32'h200, 1'b0, 1'b0, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL mret c%0d: got %h expected %h", i, obs, exp);
      end
      if (i == 1) begin
        testsRun++;
        if (obs.wdata !== 32'h88) begin
          testsFailed++;
          $display("[TB] FAIL mret_mstatus: got %h expected 00000088", obs.wdata);
        end
      end
    end
  endtask

  task automatic test_irq();
    outRec_t obs, exp;
    mMstatus = 32'h8; mMtvec = 32'h280;
    for (int i = 0; i < 6; i++) begin
      stepCycle(32'h0, 32'h40, (i == 0), 1'b0, obs, exp);
      stepCycle(32'h0, 32'h40, 1'b0, (i == 0), obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL irq_mie1 c%0d: got %h expected %h", i, obs, exp);
      end
    end
    mMstatus = 32'h0;
    for (int i = 0; i < 3; i++) begin
      stepCycle(32'h0, 32'h44, 1'b0, 1'b1, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL irq_mie0 c%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_hold();
    outRec_t obs, exp;
    mMstatus = 32'h8;
    for (int i = 0; i < 9; i++) begin
      stepCycle((i <= 3) ? 32'h2 : 32'h0, 32'h300 + 32'(i * 4), (i < 3), 1'b0, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL hold c%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_ecall_irq();
    outRec_t obs, exp;
    mMstatus = 32'h8;
    for (int i = 0; i < 9; i++) begin
      stepCycle((i == 0) ? 32'h2 : 32'h0, 32'h500, 1'b0, 1'b1, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ecall_irq c%0d: got %h expected %h", i, obs, exp);
      end
      if (i == 3) begin
        testsRun++;
        if (obs.wdata !== 32'd11) begin
          testsFailed++;
          $display("[TB] FAIL ecall_irq_cause: got %h expected 0000000b", obs.wdata);
        end
      end
    end
    irq_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    outRec_t obs, exp;
    mMstatus = 32'h0;
    for (int i = 0; i < 20; i++) begin
      stepCycle((i < 11) ? 32'h2 : 32'h0, 32'h600 + 32'(i * 4), 1'b0, 1'b0, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back c%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    outRec_t obs, exp;
    mMstatus = 32'h8;
    stepCycle(32'h2, 32'h700, 1'b0, 1'b0, obs, exp);
    stepCycle(32'h0, 32'h700, 1'b0, 1'b0, obs, exp);
    applyPending();
    expQ.delete();
    rst_n_i = 1'b0;
    #1;
    obs = {stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, redirect_o, redirect_pc_o};
    testsRun++;
    if (obs !== outRec_t'('0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_async: got %h expected 0", obs);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    mMepc = 32'h744;
    for (int i = 0; i < 7; i++) begin
      stepCycle((i == 3) ? 32'h1 : 32'h0, 32'h710, 1'b0, 1'b0, obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid c%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    outRec_t obs, exp;
    logic [31:0] exc;
    for (int i = 0; i < 420; i++) begin
      if (expQ.size() == 0 && !pendValid && ($urandom_range(0, 3) == 0)) begin
        mMstatus = $urandom; mMepc = $urandom; mMtvec = $urandom;
      end
      exc = ($urandom_range(0, 5) == 0 && i < 400) ? 32'($urandom) : 32'h0;
      stepCycle(exc, $urandom, ($urandom_range(0, 3) == 0), (i < 400) && ($urandom_range(0, 2) == 0), obs, exp);
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL random c%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_irq();
    test_hold();
    test_ecall_irq();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
